mnasser_scan_counter: RTL and testbench
=======================================

Name: mnasser_scan_counter

Overview:
Parametrised successor to the single-digit loadable counter. Provides a WIDTH-bit loadable up/down counter with hold, wrap or saturate modes and a carry/borrow pulse. The count is shown on DIGITS time-multiplexed 7-segment digits, scanned by a programmable divider. It sits behind the TinyTapeout io_in/io_out wrapper, which maps pins onto these ports.

Parameters:
WIDTH, 8, counter width in bits (>= DATA_W, >= 4)
DATA_W, 6, width of parallel load value; zero-extended to WIDTH
DIGITS, 2, number of scanned digits (1..4); digit d shows nibble count[4d+3:4d]
SCAN_DIV, 4, clock cycles per digit dwell (>= 1)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
load  in  1  synchronous parallel load strobe
load_data  in  DATA_W  load value
mode  in  2  00 hold, 01 up, 10 down, 11 hold (reserved)
sat_en  in  1  1 = saturate at limits, 0 = wrap
count  out  WIDTH  current counter value (registered)
carry  out  1  one-cycle pulse on wrap, or on a step blocked by saturation
segments  out  7  bit0=a .. bit6=g, active-high, registered
digit_sel  out  DIGITS  one-hot active-high digit enable, registered

Behaviour:
- Reset (reset=0, asynchronous): count=0, carry=0, scan divider=0, digit index=0, digit_sel=1 (digit 0), segments=7'h3F (glyph '0'). Outputs hold these values until the first clk edge after reset returns to 1.
- Counter priority per clk edge: load > mode.
  - load=1: count <= {0, load_data}; carry=0; mode ignored.
  - mode up: at count=2^WIDTH-1, sat_en=0 gives count<=0 with carry=1; sat_en=1 holds the value with carry=1. Otherwise count+1 with carry=0.
  - mode down: at count=0, sat_en=0 gives count<=2^WIDTH-1 with carry=1; sat_en=1 holds 0 with carry=1. Otherwise count-1.
  - hold/reserved: count unchanged, carry=0.
- carry is a registered single-cycle pulse. It is high in the cycle after the edge that caused it, and stays high on consecutive blocked or wrapping steps.
- Scan: divider counts 0..SCAN_DIV-1. On terminal count it returns to 0 and the digit index advances (DIGITS-1 -> 0). SCAN_DIV=1 advances every cycle. DIGITS=1 keeps digit_sel=1 permanently.
- Display: each edge registers digit_sel=onehot(index) and segments=seg7(nibble(index, count)), using pre-edge index and count. Segments therefore lag count by exactly 1 cycle. Nibble bits above WIDTH-1 read as 0.
- Glyphs for hex 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Scan runs independently of load and mode. Load does not reset the scan.
- Reset asserted mid-count or mid-scan takes effect immediately. No partial state survives.

Decomposition:
- Shared package mnasser_pkg holds:
  - mode encodings MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10
  - glyph constant table (16 x 7 bits)
- Sub-module: the existing seg7 (counter[3:0] -> segments[6:0]) is instantiated once on the selected nibble; it must match the glyph table above.
- Counter, divider and scan registers live in mnasser_scan_counter.

Test Plan:
Defaults WIDTH=8, DATA_W=6, DIGITS=2, SCAN_DIV=4.
1. Reset: hold reset=0 for 3 cycles with load=1, mode=01 -> count=0, carry=0, digit_sel=2'b01, segments=7'h3F throughout. After release, the first edge starts counting.
2. Load and up-count: load=1, load_data=6'h3F, then mode=01 for 2 cycles -> count 0x3F, 0x40, 0x41. Segments show digit-0 glyphs 71, 3F, 06 (at digit_sel=01) and digit-1 glyphs 66 (at digit_sel=10), each 1 cycle after count.
3. Wrap vs saturate up: at count=0xFF, sat_en=0 with mode=01 -> count=0x00 and carry high for 1 cycle. Repeat with sat_en=1 -> count stays 0xFF and carry high every cycle mode=01 is held.
4. Down boundary: count=0x01, mode=10, sat_en=0 -> 0x00 (carry=0), then 0xFF (carry=1). With sat_en=1 -> holds 0x00, carry=1.
5. Scan timing: idle with mode=00 -> digit_sel alternates 01/10 every 4 cycles. With SCAN_DIV=1 it toggles every cycle. A load mid-dwell does not shift the scan phase.
6. Async reset mid-operation: assert reset=0 between edges while count=0x5A and digit_sel=10 -> count=0, digit_sel=01, segments=7'h3F without waiting for clk.

Source files
------------

// File: rtl/mnasser_scan_counter_pkg.sv
// Shared definitions for the scanned up/down counter: mode encodings and
// the hex 7-segment glyph table (bit0=a .. bit6=g, active-high).
package mnasser_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Element 0 is the rightmost entry: glyph '0'.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/mnasser_scan_counter_seg7.sv
// Hex nibble to 7-segment glyph decoder (combinational).
module seg7
  import mnasser_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] segments_o
);

  assign segments_o = GLYPHS[nibble_i];

endmodule

// File: rtl/mnasser_scan_counter.sv
// Loadable up/down counter (hold/wrap/saturate) with carry pulse, shown on
// DIGITS time-multiplexed 7-segment digits scanned by a SCAN_DIV divider.
module mnasser_scan_counter
  import mnasser_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DATA_W   = 6,
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [1:0]        mode,
  input  logic              sat_en,
  output logic [WIDTH-1:0]  count,
  output logic              carry,
  output logic [6:0]        segments,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PAD_W = 4 * DIGITS;

  logic [WIDTH-1:0]  count_q, count_d;
  logic              carry_q, carry_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;

  logic              div_term;
  logic [PAD_W-1:0]  count_ext;
  logic [3:0]        nibble;

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (load) begin
      count_d = WIDTH'(load_data);
    end else begin
      case (mode_e'(mode))
        MODE_UP: begin
          if (count_q == '1) begin
            carry_d = 1'b1;
            if (!sat_en) count_d = '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (count_q == '0) begin
            carry_d = 1'b1;
            if (!sat_en) count_d = '1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    div_term = (div_q == DIV_W'(SCAN_DIV - 1));
    div_d    = div_term ? '0 : div_q + DIV_W'(1);
    idx_d    = idx_q;
    if (div_term) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Display uses the pre-edge index and count, so segments lag count by one cycle.
  always_comb begin
    count_ext = PAD_W'(count_q);
    nibble    = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (idx_q == IDX_W'(d)) nibble = count_ext[4*d +: 4];
    end
    sel_d = DIGITS'(1) << idx_q;
  end

  seg7 u_seg7 (
    .nibble_i   (nibble),
    .segments_o (seg_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      carry_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      sel_q   <= DIGITS'(1);
      seg_q   <= 7'h3F;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign count     = count_q;
  assign carry     = carry_q;
  assign segments  = seg_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_mnasser_scan_counter.sv
// Randomised self-checking bench for mnasser_scan_counter: default instance
// plus a SCAN_DIV=1 instance, both checked against a behavioural model.
module tb_mnasser_scan_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load = 1'b0;
  logic [5:0] load_data = '0;
  logic [1:0] mode = 2'b00;
  logic       sat_en = 1'b0;

  logic [7:0] count0, count1;
  logic       carry0, carry1;
  logic [6:0] seg0, seg1;
  logic [1:0] sel0, sel1;

  always #5 clk = ~clk;

  mnasser_scan_counter #(.WIDTH(8), .DATA_W(6), .DIGITS(2), .SCAN_DIV(4)) dut0 (
    .clk(clk), .reset(rst_n), .load(load), .load_data(load_data), .mode(mode),
    .sat_en(sat_en), .count(count0), .carry(carry0), .segments(seg0), .digit_sel(sel0)
  );

  mnasser_scan_counter #(.WIDTH(8), .DATA_W(6), .DIGITS(2), .SCAN_DIV(1)) dut1 (
    .clk(clk), .reset(rst_n), .load(load), .load_data(load_data), .mode(mode),
    .sat_en(sat_en), .count(count1), .carry(carry1), .segments(seg1), .digit_sel(sel1)
  );

  int tests = 0;
  int fails = 0;

  int m_count, m_k, m_carry;
  int e_sel0, e_seg0, e_sel1, e_seg1;

  logic [6:0] glyph_t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_carry = 0; m_k = 0;
    e_sel0 = 1; e_seg0 = 'h3F; e_sel1 = 1; e_seg1 = 'h3F;
  endtask

  // Digit shown after edge k is index floor(k/SCAN_DIV) mod DIGITS of the pre-edge count.
  task automatic model_edge();
    int i0, i1;
    i0 = (m_k / 4) % 2;
    i1 = m_k % 2;
    e_sel0 = 1 << i0;
    e_seg0 = glyph_t[(m_count >> (4 * i0)) & 15];
    e_sel1 = 1 << i1;
    e_seg1 = glyph_t[(m_count >> (4 * i1)) & 15];
    m_carry = 0;
    if (load) begin
      m_count = load_data;
    end else if (mode == 2'b01) begin
      if (m_count == 255) begin m_carry = 1; if (!sat_en) m_count = 0; end
      else m_count = m_count + 1;
    end else if (mode == 2'b10) begin
      if (m_count == 0) begin m_carry = 1; if (!sat_en) m_count = 255; end
      else m_count = m_count - 1;
    end
    m_k++;
  endtask

  task automatic check_all();
    chk("count0", count0, m_count);
    chk("carry0", carry0, m_carry);
    chk("seg0",   seg0,   e_seg0);
    chk("sel0",   sel0,   e_sel0);
    chk("count1", count1, m_count);
    chk("carry1", carry1, m_carry);
    chk("seg1",   seg1,   e_seg1);
    chk("sel1",   sel1,   e_sel1);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    #1;
    check_all();
  endtask

  task automatic drive(input logic l, input logic [5:0] d, input logic [1:0] md, input logic s);
    load = l; load_data = d; mode = md; sat_en = s;
  endtask

  task automatic async_pulse();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", count0, 0);
    chk("arst_carry", carry0, 0);
    chk("arst_sel",   sel0,   1);
    chk("arst_seg",   seg0,   'h3F);
    chk("arst_sel1",  sel1,   1);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Reset held for 3 edges with load and up requested
    drive(1'b1, 6'h2A, 2'b01, 1'b0);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    repeat (3) step();
    rst_n = 1'b1;
    drive(1'b0, 6'h00, 2'b01, 1'b0);
    step();
    chk("first_edge", count0, 8'h01);

    // Load and up-count; display pins
    drive(1'b1, 6'h3F, 2'b01, 1'b0);
    step(); chk("load3F", count0, 8'h3F);
    drive(1'b0, 6'h00, 2'b01, 1'b0);
    step(); chk("up40", count0, 8'h40); chk("seg_F", seg0, 7'h71);
    step(); chk("up41", count0, 8'h41); chk("seg_0", seg0, 7'h3F);
    drive(1'b0, 6'h00, 2'b00, 1'b0);
    step(); chk("seg_4", seg0, 7'h66); chk("sel_d1", sel0, 2'b10);

    // Wrap vs saturate upward
    drive(1'b1, 6'h3F, 2'b00, 1'b0); step();
    drive(1'b0, 6'h00, 2'b01, 1'b0);
    repeat (192) step();
    chk("reachFF", count0, 8'hFF);
    step(); chk("wrap_cnt", count0, 8'h00); chk("wrap_cy", carry0, 1'b1);
    drive(1'b0, 6'h00, 2'b00, 1'b0);
    step(); chk("cy_pulse", carry0, 1'b0);
    drive(1'b0, 6'h00, 2'b10, 1'b0);
    step(); chk("dwrap_cnt", count0, 8'hFF); chk("dwrap_cy", carry0, 1'b1);
    drive(1'b0, 6'h00, 2'b01, 1'b1);
    repeat (3) begin
      step(); chk("sat_cnt", count0, 8'hFF); chk("sat_cy", carry0, 1'b1);
    end
    drive(1'b0, 6'h00, 2'b00, 1'b1);
    step(); chk("sat_rel", carry0, 1'b0);

    // Down boundary
    drive(1'b1, 6'h01, 2'b00, 1'b0); step();
    drive(1'b0, 6'h00, 2'b10, 1'b0);
    step(); chk("dn00", count0, 8'h00); chk("dn00_cy", carry0, 1'b0);
    step(); chk("dnFF", count0, 8'hFF); chk("dnFF_cy", carry0, 1'b1);
    drive(1'b1, 6'h00, 2'b10, 1'b1); step();
    drive(1'b0, 6'h00, 2'b10, 1'b1);
    repeat (2) begin
      step(); chk("dsat_cnt", count0, 8'h00); chk("dsat_cy", carry0, 1'b1);
    end

    // Idle scan, then a load mid-dwell
    drive(1'b0, 6'h00, 2'b00, 1'b0);
    repeat (10) step();
    drive(1'b1, 6'h15, 2'b00, 1'b0); step();
    drive(1'b0, 6'h00, 2'b00, 1'b0);
    repeat (10) step();

    // Async reset at 0x5A while digit 1 is selected
    drive(1'b1, 6'h3F, 2'b00, 1'b0); step();
    drive(1'b0, 6'h00, 2'b01, 1'b0);
    repeat (27) step();
    chk("at5A", count0, 8'h5A);
    drive(1'b0, 6'h00, 2'b00, 1'b0);
    for (int i = 0; i < 8 && e_sel0 != 2; i++) step();
    chk("sel_is_d1", sel0, 2'b10);
    async_pulse();
    step();

    // Randomised traffic with occasional async resets
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(7) == 0), 6'($urandom), 2'($urandom), 1'($urandom));
      if ($urandom_range(199) == 0) async_pulse();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
